argo_chan_recv: RTL and testbench

Receive endpoint for an Argo channel: converts a compiled process's blocking receive (`v := <-ch`) or non-blocking receive (`select` with `default`) into pops from an `argo_fifo` channel instance. It sits between the statement-sequencing logic of a consumer process and the read side of the channel FIFO. It blocks while the channel is empty, issues exactly one pop per successful receive, and holds the received value stable for the process datapath. It also keeps receive and blocked-cycle statistics.

---
 rtl/argo_chan_recv.sv | 129 ++++++++++++
 tb/tb_argo_chan_recv.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argo_chan_recv.sv
// argo_chan_recv: receive endpoint for an Argo channel.
// Turns a process's blocking receive (v := <-ch) or non-blocking receive
// (select with default) into single pops from the read side of an argo_fifo.
// It blocks while the channel is empty, holds the received value stable for
// the process datapath, and keeps receive / blocked-cycle statistics.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   recv_req       receive request level, held until recv_done
//   recv_nb        non-blocking flag, sampled with recv_req in IDLE
//   recv_done      one-cycle completion pulse
//   recv_ok        1: data received, 0: non-blocking receive found channel empty
//   recv_data      last received value, held until the next successful receive
//   blocked        high while waiting on an empty channel
//   fifo_empty     argo_fifo.empty
//   fifo_rd_en     argo_fifo.rd_en, one-cycle pop pulse
//   fifo_rd_data   argo_fifo.rd_data, valid the cycle after fifo_rd_en
//   recv_count     successful receives, wraps
//   blocked_cycles cycles spent waiting, saturates
module argo_chan_recv #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  recv_req,
    input  logic                  recv_nb,
    output logic                  recv_done,
    output logic                  recv_ok,
    output logic [DATA_WIDTH-1:0] recv_data,
    output logic                  blocked,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [CNT_WIDTH-1:0]  recv_count,
    output logic [CNT_WIDTH-1:0]  blocked_cycles
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        POP  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Next-state logic. Once POP is reached recv_req is ignored so a popped
    // element always reaches recv_data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (recv_req) begin
                    if (!fifo_empty) begin
                        state_d = POP;
                    end else if (recv_nb) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!recv_req) begin
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    state_d = POP;
                end
            end
            POP:     state_d = CAPT;
            CAPT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered Moore outputs, decoded from the next
    // state so each output is high exactly while the FSM sits in its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fifo_rd_en <= 1'b0;
            blocked    <= 1'b0;
            recv_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_rd_en <= (state_d == POP);
            blocked    <= (state_d == WAIT);
            recv_done  <= (state_d == DONE);
        end
    end

    // Result capture: rd_data is valid in CAPT, one cycle after the pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recv_ok   <= 1'b0;
            recv_data <= '0;
        end else begin
            if (state_q == CAPT) begin
                recv_ok   <= 1'b1;
                recv_data <= fifo_rd_data;
            end else if ((state_q == IDLE) && (state_d == DONE)) begin
                recv_ok   <= 1'b0;
            end
        end
    end

    // Statistics: receive count wraps, blocked-cycle count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recv_count     <= '0;
            blocked_cycles <= '0;
        end else begin
            if (state_q == CAPT) begin
                recv_count <= recv_count + CNT_WIDTH'(1);
            end
            if ((state_q == WAIT) && (blocked_cycles != CNT_MAX)) begin
                blocked_cycles <= blocked_cycles + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_argo_chan_recv.sv
// Self-checking bench for argo_chan_recv: behavioural channel FIFO, a
// reference channel model producing expected receive results into a
// scoreboard queue, and a monitor that checks every recv_done.
module tb_argo_chan_recv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        recv_req = 1'b0;
    logic        recv_nb = 1'b0;
    logic        recv_done;
    logic        recv_ok;
    logic [31:0] recv_data;
    logic        blocked;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic [31:0] recv_count;
    logic [31:0] blocked_cycles;

    argo_chan_recv #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .recv_req       (recv_req),
        .recv_nb        (recv_nb),
        .recv_done      (recv_done),
        .recv_ok        (recv_ok),
        .recv_data      (recv_data),
        .blocked        (blocked),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .recv_count     (recv_count),
        .blocked_cycles (blocked_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural argo_fifo: pop data is valid the cycle after rd_en.
    logic [31:0] model_q[$];
    logic        push_en = 1'b0;
    logic [31:0] push_data = '0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (model_q.size() == 0) begin
                check("fifo_underflow", 64'(model_q.size()), 64'd1);
            end else begin
                fifo_rd_data <= model_q.pop_front();
            end
        end
        if (push_en) model_q.push_back(push_data);
        fifo_empty <= (model_q.size() == 0);
    end

    // Reference channel and scoreboard.
    typedef struct {
        bit          ok;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_q[$];
    logic [31:0] ref_count = '0;
    logic [31:0] last_data = '0;
    int          ok_expected = 0;

    int pops_seen  = 0;
    int dones_seen = 0;
    int blk_seen   = 0;

    // Monitor: compares each completion against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (fifo_rd_en) begin
                pops_seen++;
                check("pop_on_empty", 64'(fifo_empty), 64'd0);
            end
            if (blocked) blk_seen++;
            if (recv_done) begin
                dones_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_recv_ok", 64'(recv_ok), 64'(e.ok));
                    check("sb_recv_data", 64'(recv_data), 64'(e.data));
                    check("sb_recv_count", 64'(recv_count), 64'(e.cnt));
                end
            end
        end
    end

    task automatic push_val(input logic [31:0] v, input bit to_ref);
        push_en   = 1'b1;
        push_data = v;
        if (to_ref) ref_q.push_back(v);
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic expect_ok(input logic [31:0] v);
        ref_count = ref_count + 32'd1;
        last_data = v;
        ok_expected++;
        exp_q.push_back('{1'b1, v, ref_count});
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (recv_done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    // One receive from the reference model's view; a blocking receive on an
    // empty channel is satisfied by a writer after blk_delay wait cycles.
    task automatic recv_txn(input bit nb, input int unsigned blk_delay, input logic [31:0] late_val);
        bit late = 1'b0;
        if (ref_q.size() != 0) begin
            expect_ok(ref_q.pop_front());
        end else if (nb) begin
            exp_q.push_back('{1'b0, last_data, ref_count});
        end else begin
            late = 1'b1;
        end
        recv_req = 1'b1;
        recv_nb  = nb;
        if (late) begin
            repeat (blk_delay - 1) @(negedge clk);
            expect_ok(late_val);
            push_val(late_val, 1'b0);
        end
        wait_done("txn_done_timeout");
        recv_req = 1'b0;
        recv_nb  = 1'b0;
    endtask

    initial begin
        int p0, d0, b0, cyc;
        logic [31:0] bc0;
        int done_cyc[$];

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_recv_done", 64'(recv_done), 64'd0);
        check("rst_recv_ok", 64'(recv_ok), 64'd0);
        check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_blocked", 64'(blocked), 64'd0);
        check("rst_recv_data", 64'(recv_data), 64'd0);
        check("rst_recv_count", 64'(recv_count), 64'd0);
        check("rst_blocked_cycles", 64'(blocked_cycles), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset while blocked.
        recv_req = 1'b1;
        repeat (6) @(negedge clk);
        check("wait_blocked_cycles_5", 64'(blocked_cycles), 64'd5);
        check("wait_blocked_high", 64'(blocked), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_blocked", 64'(blocked), 64'd0);
        check("arst_blocked_cycles", 64'(blocked_cycles), 64'd0);
        check("arst_recv_done", 64'(recv_done), 64'd0);
        check("arst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        recv_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_val(32'h1, 1'b1);
        recv_txn(1'b0, 1, '0);
        check("post_rst_count", 64'(recv_count), 64'd1);

        // Latency of a receive on a non-empty channel.
        push_val(32'hA5A5_0001, 1'b1);
        expect_ok(ref_q.pop_front());
        p0 = pops_seen;
        recv_req = 1'b1;
        @(negedge clk);
        check("lat_rd_en_t1", 64'(fifo_rd_en), 64'd1);
        @(negedge clk);
        check("lat_rd_en_t2", 64'(fifo_rd_en), 64'd0);
        @(negedge clk);
        check("lat_done_t3", 64'(recv_done), 64'd1);
        check("lat_data_t3", 64'(recv_data), 64'hA5A5_0001);
        check("lat_ok_t3", 64'(recv_ok), 64'd1);
        recv_req = 1'b0;
        @(negedge clk);
        check("lat_one_pop", 64'(pops_seen - p0), 64'd1);

        // Blocking receive, writer arrives after 10 cycles.
        p0 = pops_seen; b0 = blk_seen; bc0 = blocked_cycles;
        recv_txn(1'b0, 10, 32'h42);
        check("blk_recv_data", 64'(recv_data), 64'h42);
        @(negedge clk);
        check("blk_blocked_seen", 64'(blk_seen - b0), 64'd10);
        check("blk_blocked_cycles", 64'(blocked_cycles - bc0), 64'd10);
        check("blk_one_pop", 64'(pops_seen - p0), 64'd1);

        // Non-blocking receive on an empty channel.
        p0 = pops_seen;
        recv_txn(1'b1, 1, '0);
        check("nb_recv_ok", 64'(recv_ok), 64'd0);
        check("nb_recv_data_kept", 64'(recv_data), 64'h42);
        @(negedge clk);
        check("nb_no_pop", 64'(pops_seen - p0), 64'd0);

        // Aborted blocking receive.
        p0 = pops_seen; d0 = dones_seen;
        recv_req = 1'b1;
        repeat (3) @(negedge clk);
        recv_req = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_blocked_low", 64'(blocked), 64'd0);
        push_val(32'h7, 1'b1);
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(dones_seen - d0), 64'd0);
        check("abort_no_pop", 64'(pops_seen - p0), 64'd0);
        check("abort_fifo_count", 64'(model_q.size()), 64'd1);
        recv_txn(1'b0, 1, '0);

        // Back-to-back receives of 1..8 with recv_req held.
        for (int i = 1; i <= 8; i++) push_val(32'(i), 1'b1);
        for (int i = 1; i <= 8; i++) expect_ok(ref_q.pop_front());
        p0 = pops_seen;
        cyc = 0;
        recv_req = 1'b1;
        while (done_cyc.size() < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (recv_done) done_cyc.push_back(cyc);
        end
        recv_req = 1'b0;
        check("b2b_done_count", 64'(done_cyc.size()), 64'd8);
        for (int i = 1; i < done_cyc.size(); i++)
            check("b2b_done_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd4);
        repeat (3) @(negedge clk);
        check("b2b_fifo_empty", 64'(model_q.size()), 64'd0);
        check("b2b_pops", 64'(pops_seen - p0), 64'd8);
        check("b2b_last_data", 64'(recv_data), 64'd8);

        // Receive counter wrap.
        force dut.recv_count = 32'hFFFF_FFFF;
        #1;
        release dut.recv_count;
        ref_count = 32'hFFFF_FFFF;
        @(negedge clk);
        push_val(32'hDEAD_BEEF, 1'b1);
        recv_txn(1'b0, 1, '0);
        check("wrap_recv_count", 64'(recv_count), 64'd0);

        // Randomized mix of preloaded, blocking and non-blocking receives.
        for (int it = 0; it < 40; it++) begin
            int unsigned k;
            k = $urandom_range(0, 3);
            for (int j = 0; j < int'(k); j++) push_val($urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            recv_txn(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom);
        end
        while (ref_q.size() != 0) recv_txn(1'b0, 1, '0);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("total_pops", 64'(pops_seen), 64'(ok_expected));
        check("final_fifo_empty", 64'(model_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
